// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered one-hot grant, encoded grant index
// and a grant-hold quota that lets one owner keep the grant for up to MAX_HOLD cycles.
module rr_arbiter_n #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 4,
  localparam int IDW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDW-1:0]     gnt_id
);

  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] MAX_HOLD_C = HCW'(MAX_HOLD);
  localparam logic [IDW:0]   NUM_REQ_W  = (IDW + 1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_IDX   = IDW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE    = {{(NUM_REQ - 1){1'b0}}, 1'b1};

  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic               gnt_valid_reg, gnt_valid_next;
  logic [IDW-1:0]     gnt_id_reg, gnt_id_next;
  logic [IDW-1:0]     ptr_reg, ptr_next;
  logic [HCW-1:0]     hold_cnt_reg, hold_cnt_next;

  // Rotate the request vector so that bit 0 corresponds to the requester at ptr.
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  assign req_dbl = {req, req};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign req_rot[gi] = req_dbl[ptr_reg + gi];
    end
  endgenerate

  logic           rot_hit;
  logic [IDW-1:0] rot_off;

  // Descending scan so the lowest set offset is the one left standing.
  always_comb begin
    rot_hit = 1'b0;
    rot_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        rot_hit = 1'b1;
        rot_off = IDW'(k);
      end
    end
  end

  logic [IDW:0]   win_sum, win_wrap;
  logic [IDW-1:0] win_idx;
  assign win_sum  = {1'b0, ptr_reg} + {1'b0, rot_off};
  assign win_wrap = win_sum - NUM_REQ_W;
  assign win_idx  = (win_sum >= NUM_REQ_W) ? win_wrap[IDW-1:0] : win_sum[IDW-1:0];

  logic owner_req, keep;
  assign owner_req = |(req & gnt_reg);
  assign keep      = owner_req && (hold_cnt_reg < MAX_HOLD_C);

  always_comb begin
    gnt_next       = gnt_reg;
    gnt_valid_next = gnt_valid_reg;
    gnt_id_next    = gnt_id_reg;
    ptr_next       = ptr_reg;
    hold_cnt_next  = hold_cnt_reg;
    if (keep) begin
      hold_cnt_next = hold_cnt_reg + HCW'(1);
    end else if (rot_hit) begin
      gnt_next       = ONE << win_idx;
      gnt_valid_next = 1'b1;
      gnt_id_next    = win_idx;
      hold_cnt_next  = HCW'(1);
      ptr_next       = (win_idx == LAST_IDX) ? '0 : win_idx + IDW'(1);
    end else begin
      // Idle: drop the grant but keep ptr so fairness survives gaps in traffic.
      gnt_next       = '0;
      gnt_valid_next = 1'b0;
      gnt_id_next    = '0;
      hold_cnt_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_reg       <= '0;
      gnt_valid_reg <= 1'b0;
      gnt_id_reg    <= '0;
      ptr_reg       <= '0;
      hold_cnt_reg  <= '0;
    end else begin
      gnt_reg       <= gnt_next;
      gnt_valid_reg <= gnt_valid_next;
      gnt_id_reg    <= gnt_id_next;
      ptr_reg       <= ptr_next;
      hold_cnt_reg  <= hold_cnt_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = gnt_valid_reg;
  assign gnt_id    = gnt_id_reg;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n: hold-quota unit (4x4), pure round robin (4x1)
// and a non-power-of-two unit (3x1), all sharing clock and reset.
module tb_rr_arbiter_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] req_a, gnt_a;
  logic       gv_a;
  logic [1:0] id_a;
  logic [3:0] req_b, gnt_b;
  logic       gv_b;
  logic [1:0] id_b;
  logic [2:0] req_c, gnt_c;
  logic       gv_c;
  logic [1:0] id_c;

  int n_assert = 0;
  int n_fail   = 0;

  rr_arbiter_n #(.NUM_REQ(4), .MAX_HOLD(4)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_valid(gv_a), .gnt_id(id_a));
  rr_arbiter_n #(.NUM_REQ(4), .MAX_HOLD(1)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_valid(gv_b), .gnt_id(id_b));
  rr_arbiter_n #(.NUM_REQ(3), .MAX_HOLD(1)) u_c (
    .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_valid(gv_c), .gnt_id(id_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] idx_of(input logic [31:0] v);
    idx_of = 0;
    for (int i = 31; i >= 0; i--) if (v[i]) idx_of = i;
  endfunction

  // Compare grant, valid and index of one unit against an expected one-hot grant.
  task automatic chk(input string tag, input logic [31:0] g, input logic v,
                     input logic [31:0] id, input logic [31:0] exp_g);
    check({tag, "_gnt"}, g, exp_g);
    check({tag, "_valid"}, {31'b0, v}, {31'b0, exp_g != 0});
    check({tag, "_id"}, id, idx_of(exp_g));
    check({tag, "_onehot"}, {31'b0, $onehot0(g)}, 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst   = 1'b0;
    req_a = 4'b1111;
    req_b = 4'b1111;
    req_c = 3'b111;

    // Reset held with all requests high: nothing granted.
    repeat (5) begin
      tick();
      chk("rst_a", {28'b0, gnt_a}, gv_a, {30'b0, id_a}, 32'h0);
    end
    chk("rst_b", {28'b0, gnt_b}, gv_b, {30'b0, id_b}, 32'h0);

    // Release: quota rotation on a, per-cycle rotation on b and c.
    rst = 1'b1;
    for (int c = 0; c < 17; c++) begin
      tick();
      chk($sformatf("quota_a%0d", c), {28'b0, gnt_a}, gv_a, {30'b0, id_a}, 32'd1 << ((c / 4) % 4));
      chk($sformatf("rot_b%0d", c), {28'b0, gnt_b}, gv_b, {30'b0, id_b}, 32'd1 << (c % 4));
      chk($sformatf("rot_c%0d", c), {29'b0, gnt_c}, gv_c, {30'b0, id_c}, 32'd1 << (c % 3));
    end

    // Idle keeps ptr at 1 (last winner 0), so 1001 goes to requester 3.
    req_b = 4'b0000;
    tick();
    chk("idle_b", {28'b0, gnt_b}, gv_b, {30'b0, id_b}, 32'h0);
    req_b = 4'b1001;
    tick();
    chk("ptr_keep_b", {28'b0, gnt_b}, gv_b, {30'b0, id_b}, 32'b1000);
    req_b = 4'b0000;
    req_c = 3'b000;

    // Single requester: continuous grant across quota boundaries.
    do_reset();
    req_a = 4'b0100;
    rst   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("single_a%0d", c), {28'b0, gnt_a}, gv_a, {30'b0, id_a}, 32'b0100);
    end

    // Early release: req0 drops after two grant cycles.
    do_reset();
    req_a = 4'b1011;
    rst   = 1'b1;
    tick();
    chk("early_a0", {28'b0, gnt_a}, gv_a, {30'b0, id_a}, 32'b0001);
    tick();
    chk("early_a1", {28'b0, gnt_a}, gv_a, {30'b0, id_a}, 32'b0001);
    req_a = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("early_r1_%0d", c), {28'b0, gnt_a}, gv_a, {30'b0, id_a}, 32'b0010);
    end
    tick();
    chk("early_r3", {28'b0, gnt_a}, gv_a, {30'b0, id_a}, 32'b1000);

    // Mid-tenure asynchronous reset, then ptr restarts at 0.
    do_reset();
    req_a = 4'b0100;
    rst   = 1'b1;
    tick();
    tick();
    chk("mid_pre", {28'b0, gnt_a}, gv_a, {30'b0, id_a}, 32'b0100);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_async", {28'b0, gnt_a}, gv_a, {30'b0, id_a}, 32'h0);
    req_a = 4'b1100;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_after", {28'b0, gnt_a}, gv_a, {30'b0, id_a}, 32'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
